bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single 16-bit external bus between two requesters: the instruction fetcher (I port) and the load/store unit (D port).
- Tracks the owner of the bus with a registered grant state machine and steers the owner's address, size, write-enable, store data and VPA onto the bus.
- Routes ACK only to the current owner.
- A watchdog aborts any transaction that is never acknowledged and returns an error strobe to the owner.

Parameters:
- TIMEOUT, 255, cycles in one grant without ack_i before abort; 0 disables the watchdog.
- TW, 8, width of the watchdog counter; TIMEOUT must be less than 2^TW.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- reset_i  in  1  reset, asynchronous, active-high
- i_adr_i  in  64  fetch address
- i_size_i  in  2  fetch size; 00 means no request
- i_vpa_i  in  1  fetch valid-program-address qualifier
- i_ack_o  out  1  fetch transfer complete
- i_err_o  out  1  fetch transfer aborted by the watchdog
- d_adr_i  in  64  data address
- d_size_i  in  2  data size; 00 means no request
- d_we_i  in  1  data write enable
- d_dat_i  in  16  store data
- d_ack_o  out  1  data transfer complete
- d_err_o  out  1  data transfer aborted by the watchdog
- adr_o  out  64  external address
- size_o  out  2  external size
- we_o  out  1  external write enable
- dat_o  out  16  external write data
- vpa_o  out  1  external opcode-fetch qualifier
- ack_i  in  1  external acknowledge
- dat_i  in  16  external read data
- rdat_o  out  16  read data, dat_i broadcast to both ports unconditionally
- gnt_o  out  2  owner status: 00 idle, 01 I, 10 D

Behaviour:
- States: IDLE, GNT_I, GNT_D. Registered bit last_d records the most recent owner.
- Reset: asynchronous. While reset_i is high and after release:
  - state is IDLE, last_d is 1 (so I wins the first contention), watchdog count is 0.
  - All outputs are 0.
- Request: port X requests when X_size_i != 00. Size 11 counts as a request and passes through unfiltered.
- Arbitration function (evaluated in IDLE, and at the end of any grant):
  - Only I requests: I wins. Only D requests: D wins.
  - Both request: round-robin; D wins if last_d = 0, otherwise I wins.
  - Neither requests: IDLE.
  - Entering GNT_D sets last_d = 1; entering GNT_I sets last_d = 0.
- IDLE:
  - Bus outputs are all 0, so size_o = 00 (no cycle).
  - The next state is the arbitration result, so a grant takes effect one cycle after the request is first seen.
- GNT_X outputs (combinational from X's inputs):
  - adr_o, size_o come from X.
  - we_o = d_we_i if X = D, else 0.
  - dat_o = d_dat_i if X = D, else 0.
  - vpa_o = i_vpa_i if X = I, else 0.
- GNT_X completion:
  - X_ack_o = ack_i in the same cycle (combinational). The other port's ack stays 0.
  - On ack_i, re-arbitrate with both ports' current requests. The other port wins if it is requesting; otherwise X keeps the bus with no bubble if it still requests (e.g. the fetcher's high-halfword cycle).
- GNT_X abandon: if X_size_i = 00 while ack_i = 0, the cycle is abandoned. The next state is arbitration with X treated as not requesting; no ack and no err are issued.
- Watchdog:
  - Counter clears on every grant entry and increments each GNT cycle without ack_i.
  - When the counter reaches TIMEOUT with ack_i still 0:
    - X_err_o pulses for exactly that cycle.
    - Bus outputs are forced to 0 in that cycle.
    - The next state is arbitration with X excluded for one decision.
  - ack_i and timeout in the same cycle: ack wins and no err is issued.
- Stray ack_i in IDLE: ignored; no ack output asserts.
- Outputs never present two owners at once. gnt_o = 01 in GNT_I, 10 in GNT_D, 00 in IDLE.

Test Plan:
- Reset then I request at cycle 1 (i_adr_i = 0xFFFF_FFFF_FFFF_FF00, size 10, vpa 1): gnt_o = 01 at cycle 2, adr_o and size_o mirror I, vpa_o = 1. ack_i at cycle 4 gives i_ack_o = 1 that cycle only and d_ack_o = 0.
- Both request from IDLE after reset: I granted first. On its ack, D (d_we_i = 1, d_dat_i = 0xBEEF) is granted with no idle cycle, and we_o = 1, dat_o = 0xBEEF. On D's ack with both still requesting, I is granted.
- I alone does two back-to-back transfers at adr and adr+2: gnt_o stays 01 through the ack with no bubble, and adr_o changes to +2 in the cycle after the ack.
- TIMEOUT = 4, D granted, ack_i held 0: d_err_o pulses for one cycle after 4 un-acked grant cycles, size_o = 00 that cycle, then the pending I request is granted.
- Ack and timeout coincide: d_ack_o = 1, d_err_o = 0. Also, assert reset_i mid-grant: gnt_o and size_o go to 0 immediately (asynchronously).
- I drops size to 00 mid-grant without ack: gnt_o returns to 00 next cycle, no i_ack_o or i_err_o is seen, and a stray ack_i in IDLE produces no acks.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-port bus arbiter: the fetch (I) and load/store (D) ports share one external bus.
// Round-robin grant FSM, owner-only ack routing, and a watchdog that aborts un-acked cycles.
//
// state | meaning
// IDLE  | no owner, bus outputs held at 0
// GNT_I | fetcher owns the bus
// GNT_D | load/store unit owns the bus
module bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] i_adr_i,
  input  logic [1:0]  i_size_i,
  input  logic        i_vpa_i,
  output logic        i_ack_o,
  output logic        i_err_o,
  input  logic [63:0] d_adr_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_we_i,
  input  logic [15:0] d_dat_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [63:0] adr_o,
  output logic [1:0]  size_o,
  output logic        we_o,
  output logic [15:0] dat_o,
  output logic        vpa_o,
  input  logic        ack_i,
  input  logic [15:0] dat_i,
  output logic [15:0] rdat_o,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [TW-1:0] LP_TIMEOUT = TW'(TIMEOUT);
  localparam logic          LP_WD_EN   = (TIMEOUT != 0);

  state_t          r_state;
  state_t          w_next;
  logic            r_last_d;
  logic            w_last_d_next;
  logic [TW-1:0]   r_cnt;
  logic [TW-1:0]   w_cnt_next;
  logic            w_req_i;
  logic            w_req_d;
  logic            w_timeout;

  // Both requesting: the port that did not own the bus last goes first.
  function automatic state_t arb(input logic req_i, input logic req_d, input logic last_d);
    if (req_i && req_d) return last_d ? GNT_I : GNT_D;
    else if (req_i)     return GNT_I;
    else if (req_d)     return GNT_D;
    else                return IDLE;
  endfunction

  assign w_req_i   = |i_size_i;
  assign w_req_d   = |d_size_i;
  assign w_timeout = LP_WD_EN && (r_cnt == LP_TIMEOUT) && !ack_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_last_d <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_last_d <= w_last_d_next;
      r_cnt    <= w_cnt_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    i_ack_o = 1'b0;
    i_err_o = 1'b0;
    d_ack_o = 1'b0;
    d_err_o = 1'b0;
    adr_o   = '0;
    size_o  = '0;
    we_o    = 1'b0;
    dat_o   = '0;
    vpa_o   = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = arb(w_req_i, w_req_d, r_last_d);
      end
      GNT_I: begin
        i_ack_o = ack_i;
        if (ack_i) begin
          w_next = arb(w_req_i, w_req_d, r_last_d);
        end else if (!w_req_i) begin
          w_next = arb(1'b0, w_req_d, r_last_d);
        end else if (w_timeout) begin
          i_err_o = 1'b1;
          w_next  = arb(1'b0, w_req_d, r_last_d);
        end
        // The aborted cycle must not be seen on the bus.
        if (!(w_timeout && w_req_i)) begin
          adr_o  = i_adr_i;
          size_o = i_size_i;
          vpa_o  = i_vpa_i;
        end
      end
      GNT_D: begin
        d_ack_o = ack_i;
        if (ack_i) begin
          w_next = arb(w_req_i, w_req_d, r_last_d);
        end else if (!w_req_d) begin
          w_next = arb(w_req_i, 1'b0, r_last_d);
        end else if (w_timeout) begin
          d_err_o = 1'b1;
          w_next  = arb(w_req_i, 1'b0, r_last_d);
        end
        if (!(w_timeout && w_req_d)) begin
          adr_o  = d_adr_i;
          size_o = d_size_i;
          we_o   = d_we_i;
          dat_o  = d_dat_i;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_last_d_next = r_last_d;
    if (w_next == GNT_D)      w_last_d_next = 1'b1;
    else if (w_next == GNT_I) w_last_d_next = 1'b0;
  end

  // Each new transaction (grant entry or back-to-back after an ack) restarts the count.
  always_comb begin
    w_cnt_next = '0;
    if (LP_WD_EN && (w_next != IDLE) && (w_next == r_state) && !ack_i)
      w_cnt_next = r_cnt + 1'b1;
  end

  assign gnt_o  = (r_state == GNT_I) ? 2'b01 :
                  (r_state == GNT_D) ? 2'b10 : 2'b00;
  assign rdat_o = reset_i ? 16'h0000 : dat_i;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter (TIMEOUT = 4): per-cycle table of inputs and
// hand-computed outputs, plus watchdog, ack/timeout collision and async reset sequences.
module tb_bus_arbiter;

  localparam logic [63:0] A   = 64'hFFFF_FFFF_FFFF_FF00;
  localparam logic [63:0] A2  = 64'hFFFF_FFFF_FFFF_FF02;
  localparam logic [63:0] DA  = 64'h0000_0000_1000_0040;

  typedef struct {
    logic [1:0]  isz;
    logic [63:0] iadr;
    logic        ivpa;
    logic [1:0]  dsz;
    logic [63:0] dadr;
    logic        dwe;
    logic [15:0] ddat;
    logic        ack;
    logic [15:0] rd;
    logic [1:0]  e_gnt;
    logic [63:0] e_adr;
    logic [1:0]  e_sz;
    logic        e_we;
    logic [15:0] e_dat;
    logic        e_vpa;
    logic        e_iack;
    logic        e_dack;
    logic        e_ierr;
    logic        e_derr;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] i_adr_i;
  logic [1:0]  i_size_i;
  logic        i_vpa_i;
  logic        i_ack_o;
  logic        i_err_o;
  logic [63:0] d_adr_i;
  logic [1:0]  d_size_i;
  logic        d_we_i;
  logic [15:0] d_dat_i;
  logic        d_ack_o;
  logic        d_err_o;
  logic [63:0] adr_o;
  logic [1:0]  size_o;
  logic        we_o;
  logic [15:0] dat_o;
  logic        vpa_o;
  logic        ack_i;
  logic [15:0] dat_i;
  logic [15:0] rdat_o;
  logic [1:0]  gnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(.TIMEOUT(4), .TW(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .i_adr_i(i_adr_i), .i_size_i(i_size_i), .i_vpa_i(i_vpa_i),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_adr_i(d_adr_i), .d_size_i(d_size_i), .d_we_i(d_we_i), .d_dat_i(d_dat_i),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .adr_o(adr_o), .size_o(size_o), .we_o(we_o), .dat_o(dat_o), .vpa_o(vpa_o),
    .ack_i(ack_i), .dat_i(dat_i), .rdat_o(rdat_o), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input vec_t v);
    i_size_i = v.isz;  i_adr_i = v.iadr; i_vpa_i = v.ivpa;
    d_size_i = v.dsz;  d_adr_i = v.dadr; d_we_i  = v.dwe; d_dat_i = v.ddat;
    ack_i    = v.ack;  dat_i   = v.rd;
  endtask

  task automatic check(input vec_t v, input string name);
    n_tests++;
    if (gnt_o !== v.e_gnt || adr_o !== v.e_adr || size_o !== v.e_sz || we_o !== v.e_we ||
        dat_o !== v.e_dat || vpa_o !== v.e_vpa || i_ack_o !== v.e_iack ||
        d_ack_o !== v.e_dack || i_err_o !== v.e_ierr || d_err_o !== v.e_derr ||
        rdat_o !== v.rd) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b adr=%h sz=%b we=%b dat=%h vpa=%b iack=%b dack=%b ierr=%b derr=%b rdat=%h | want gnt=%b adr=%h sz=%b we=%b dat=%h vpa=%b iack=%b dack=%b ierr=%b derr=%b rdat=%h",
               name, gnt_o, adr_o, size_o, we_o, dat_o, vpa_o, i_ack_o, d_ack_o, i_err_o, d_err_o, rdat_o,
               v.e_gnt, v.e_adr, v.e_sz, v.e_we, v.e_dat, v.e_vpa, v.e_iack, v.e_dack, v.e_ierr, v.e_derr, v.rd);
    end
  endtask

  // Drive one cycle's inputs, check the combinational outputs mid-cycle, then clock.
  task automatic step(input vec_t v, input string name);
    drive(v);
    #1;
    check(v, name);
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[15];
  vec_t w;

  initial begin
    tbl[0]  = '{2'd0, 64'd0, 1'b0, 2'd0, 64'd0, 1'b0, 16'h0,    1'b0, 16'h1234, 2'b00, 64'd0, 2'd0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'd2, A,     1'b1, 2'd0, 64'd0, 1'b0, 16'h0,    1'b0, 16'h1234, 2'b00, 64'd0, 2'd0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'd2, A,     1'b1, 2'd0, 64'd0, 1'b0, 16'h0,    1'b0, 16'h5678, 2'b01, A,     2'd2, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'd2, A,     1'b1, 2'd0, 64'd0, 1'b0, 16'h0,    1'b0, 16'h5678, 2'b01, A,     2'd2, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'd2, A,     1'b1, 2'd0, 64'd0, 1'b0, 16'h0,    1'b1, 16'hA5A5, 2'b01, A,     2'd2, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'd2, A,     1'b1, 2'd1, DA,    1'b1, 16'hBEEF, 1'b0, 16'h0001, 2'b01, A,     2'd2, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'd2, A,     1'b1, 2'd1, DA,    1'b1, 16'hBEEF, 1'b1, 16'h0002, 2'b01, A,     2'd2, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'd2, A,     1'b1, 2'd1, DA,    1'b1, 16'hBEEF, 1'b0, 16'h0003, 2'b10, DA,    2'd1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'd2, A,     1'b1, 2'd1, DA,    1'b1, 16'hBEEF, 1'b1, 16'h0004, 2'b10, DA,    2'd1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{2'd2, A,     1'b1, 2'd0, DA,    1'b1, 16'hBEEF, 1'b0, 16'h0005, 2'b01, A,     2'd2, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'd2, A,     1'b1, 2'd0, DA,    1'b1, 16'hBEEF, 1'b1, 16'h0006, 2'b01, A,     2'd2, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2'd2, A2,    1'b1, 2'd0, 64'd0, 1'b0, 16'h0,    1'b0, 16'h0007, 2'b01, A2,    2'd2, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{2'd0, A2,    1'b1, 2'd0, 64'd0, 1'b0, 16'h0,    1'b0, 16'h0008, 2'b01, A2,    2'd0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{2'd0, 64'd0, 1'b0, 2'd0, 64'd0, 1'b0, 16'h0,    1'b1, 16'h0009, 2'b00, 64'd0, 2'd0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{2'd0, 64'd0, 1'b0, 2'd0, 64'd0, 1'b0, 16'h0,    1'b0, 16'h000A, 2'b00, 64'd0, 2'd0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_i = 1'b1;
    drive(tbl[0]);
    dat_i = 16'hFFFF;
    #1;
    n_tests++;
    if (gnt_o !== 2'b00 || size_o !== 2'b00 || adr_o !== 64'd0 || rdat_o !== 16'h0 ||
        i_ack_o !== 1'b0 || d_ack_o !== 1'b0 || i_err_o !== 1'b0 || d_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b sz=%b adr=%h rdat=%h acks=%b%b errs=%b%b want all zero",
               gnt_o, size_o, adr_o, rdat_o, i_ack_o, d_ack_o, i_err_o, d_err_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    for (int k = 0; k < 15; k++) step(tbl[k], $sformatf("table[%0d]", k));

    // Watchdog: D wins (last owner was I), times out after 4 un-acked cycles, I follows.
    w = '{2'd2, A, 1'b1, 2'd2, DA, 1'b0, 16'h0, 1'b0, 16'h0, 2'b00, 64'd0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(w, "wd_idle");
    w.e_gnt = 2'b10; w.e_adr = DA; w.e_sz = 2'd2;
    for (int k = 1; k <= 4; k++) step(w, $sformatf("wd_wait[%0d]", k));
    w.e_adr = 64'd0; w.e_sz = 2'd0; w.e_derr = 1'b1;
    step(w, "wd_abort");
    w = '{2'd2, A, 1'b1, 2'd2, DA, 1'b0, 16'h0, 1'b0, 16'h0, 2'b01, A, 2'd2, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    step(w, "wd_next_i");
    w.ack = 1'b1; w.e_iack = 1'b1;
    step(w, "wd_i_ack");

    // Ack arrives in exactly the cycle the watchdog would fire: ack wins.
    w = '{2'd0, 64'd0, 1'b0, 2'd2, DA, 1'b0, 16'h0, 1'b0, 16'h0, 2'b10, DA, 2'd2, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) step(w, $sformatf("coin_wait[%0d]", k));
    w.ack = 1'b1; w.e_dack = 1'b1;
    step(w, "coin_ack");

    // Asynchronous reset in the middle of a D grant.
    w.ack = 1'b0; w.e_dack = 1'b0; w.rd = 16'h4321;
    drive(w);
    #1;
    check(w, "pre_reset_grant");
    #1;
    reset_i = 1'b1;
    #1;
    n_tests++;
    if (gnt_o !== 2'b00 || size_o !== 2'b00 || adr_o !== 64'd0 || rdat_o !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: got gnt=%b sz=%b adr=%h rdat=%h want gnt=00 sz=00 adr=0 rdat=0",
               gnt_o, size_o, adr_o, rdat_o);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // After reset last_d is 1, so I wins the first contention.
    w = '{2'd1, A, 1'b0, 2'd2, DA, 1'b1, 16'h1111, 1'b0, 16'h0, 2'b00, 64'd0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(w, "post_reset_idle");
    w.e_gnt = 2'b01; w.e_adr = A; w.e_sz = 2'd1;
    step(w, "post_reset_i_first");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
